// File: rtl/pushdown_stack_ctrl_if.sv
// Push/pop request bundle between the stack-machine sequencer (master)
// and the LIFO storage block (slave).
interface pushdown_stack_ctrl_if #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
);
  // push/pop are single-cycle requests sampled on every rising edge; there is
  // no back-pressure. A request that cannot be honoured is dropped and
  // reported by a one-cycle overflow/underflow pulse. valid marks the one
  // cycle in which data_out carries a freshly popped value.
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data_in,
    input  data_out, valid, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, valid, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/pushdown_stack_ctrl.sv
// LIFO storage with registered pop output, replace (push+pop) and
// pass-through on empty, plus overflow/underflow status pulses.
module pushdown_stack_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input logic                   clk,
  input logic                   rst,
  pushdown_stack_ctrl_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             empty;
  logic             full;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [CW-1:0]    sp_minus_one;

  assign empty        = (sp == '0);
  assign full         = (sp == CW'(DEPTH));
  assign sp_minus_one = sp - CW'(1);
  // sp is the first free slot; the top of stack sits one below it.
  assign wr_idx       = AW'(sp);
  assign top_idx      = AW'(sp_minus_one);

  // Storage is deliberately not reset; only the pointer defines contents.
  always_ff @(posedge clk) begin
    if (bus.push && !bus.pop && !full) begin
      mem[wr_idx] <= bus.data_in;
    end else if (bus.push && bus.pop && !empty) begin
      mem[top_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp          <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      unique case ({bus.push, bus.pop})
        2'b10: begin
          if (full) overflow_q <= 1'b1;
          else      sp         <= sp + CW'(1);
        end
        2'b01: begin
          if (empty) begin
            underflow_q <= 1'b1;
          end else begin
            data_out_q <= mem[top_idx];
            sp         <= sp_minus_one;
            valid_q    <= 1'b1;
          end
        end
        2'b11: begin
          // Replace returns the old top; on an empty stack the input passes straight through.
          data_out_q <= empty ? bus.data_in : mem[top_idx];
          valid_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = sp;
endmodule

// File: tb/tb_pushdown_stack_ctrl.sv
// Directed bench for pushdown_stack_ctrl (WIDTH=8, DEPTH=8) with
// hand-computed expectations for every scenario.
module tb_pushdown_stack_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  pushdown_stack_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pushdown_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one request for one rising edge, return 1ns after it
  task automatic drive(input logic p, input logic q, input logic [WIDTH-1:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (bus.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else passed++;
    total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", bus.empty, bus.full); else passed++;
    total++; if (bus.data_out !== 8'h00) $display("FAIL reset_data_out got=%h exp=00", bus.data_out); else passed++;
    total++; if ({bus.valid, bus.overflow, bus.underflow} !== 3'b000) $display("FAIL reset_pulses got=%b exp=000", {bus.valid, bus.overflow, bus.underflow}); else passed++;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b1, 1'b0, 8'h04);
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.count !== 4'd3 || bus.data_out !== 8'h04 || bus.valid !== 1'b1) $display("FAIL midrst_pre count=%0d data=%h valid=%b exp 3/04/1", bus.count, bus.data_out, bus.valid); else passed++;
    // assert reset between edges and look before any clock arrives
    #2 rst = 1'b1;
    #1;
    total++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) $display("FAIL midrst_count count=%0d empty=%b exp 0/1", bus.count, bus.empty); else passed++;
    total++; if (bus.data_out !== 8'h00 || bus.valid !== 1'b0) $display("FAIL midrst_out data=%h valid=%b exp 00/0", bus.data_out, bus.valid); else passed++;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_push_pop();
    drive(1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b0, 8'h33);
    total++; if (bus.count !== 4'd3 || bus.empty !== 1'b0 || bus.valid !== 1'b0) $display("FAIL pp_count count=%0d empty=%b valid=%b exp 3/0/0", bus.count, bus.empty, bus.valid); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'h33 || bus.valid !== 1'b1) $display("FAIL pp_pop1 data=%h valid=%b exp 33/1", bus.data_out, bus.valid); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'h22 || bus.valid !== 1'b1) $display("FAIL pp_pop2 data=%h valid=%b exp 22/1", bus.data_out, bus.valid); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'h11 || bus.valid !== 1'b1 || bus.empty !== 1'b1) $display("FAIL pp_pop3 data=%h valid=%b empty=%b exp 11/1/1", bus.data_out, bus.valid, bus.empty); else passed++;
    drive(1'b0, 1'b0, 8'h00);
    total++; if (bus.valid !== 1'b0 || bus.data_out !== 8'h11) $display("FAIL pp_hold valid=%b data=%h exp 0/11", bus.valid, bus.data_out); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'hA0 + 8'(i));
    total++; if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b0) $display("FAIL ovf_fill count=%0d full=%b ovf=%b exp 8/1/0", bus.count, bus.full, bus.overflow); else passed++;
    drive(1'b1, 1'b0, 8'hFF);
    total++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8 || bus.valid !== 1'b0) $display("FAIL ovf_pulse ovf=%b count=%0d valid=%b exp 1/8/0", bus.overflow, bus.count, bus.valid); else passed++;
    drive(1'b0, 1'b0, 8'h00);
    total++; if (bus.overflow !== 1'b0 || bus.full !== 1'b1) $display("FAIL ovf_clear ovf=%b full=%b exp 0/1", bus.overflow, bus.full); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'hA7 || bus.valid !== 1'b1 || bus.count !== 4'd7) $display("FAIL ovf_pop data=%h valid=%b count=%0d exp A7/1/7", bus.data_out, bus.valid, bus.count); else passed++;
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'hA0 || bus.empty !== 1'b1) $display("FAIL ovf_drain data=%h empty=%b exp A0/1", bus.data_out, bus.empty); else passed++;
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.underflow !== 1'b1 || bus.valid !== 1'b0) $display("FAIL unf_pulse unf=%b valid=%b exp 1/0", bus.underflow, bus.valid); else passed++;
    total++; if (bus.data_out !== 8'hA0 || bus.count !== 4'd0) $display("FAIL unf_hold data=%h count=%0d exp A0/0", bus.data_out, bus.count); else passed++;
    drive(1'b0, 1'b0, 8'h00);
    total++; if (bus.underflow !== 1'b0) $display("FAIL unf_clear unf=%b exp 0", bus.underflow); else passed++;
  endtask

  task automatic test_replace();
    drive(1'b1, 1'b0, 8'h10);
    drive(1'b1, 1'b0, 8'h20);
    drive(1'b1, 1'b1, 8'h99);
    total++; if (bus.data_out !== 8'h20 || bus.valid !== 1'b1 || bus.count !== 4'd2) $display("FAIL rep_out data=%h valid=%b count=%0d exp 20/1/2", bus.data_out, bus.valid, bus.count); else passed++;
    total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) $display("FAIL rep_flags ovf=%b unf=%b exp 0/0", bus.overflow, bus.underflow); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'h99 || bus.count !== 4'd1) $display("FAIL rep_pop1 data=%h count=%0d exp 99/1", bus.data_out, bus.count); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'h10 || bus.count !== 4'd0) $display("FAIL rep_pop2 data=%h count=%0d exp 10/0", bus.data_out, bus.count); else passed++;
  endtask

  task automatic test_replace_full();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'hB0 + 8'(i));
    drive(1'b1, 1'b1, 8'hC3);
    total++; if (bus.data_out !== 8'hB7 || bus.valid !== 1'b1 || bus.overflow !== 1'b0 || bus.count !== 4'd8) $display("FAIL repf_out data=%h valid=%b ovf=%b count=%0d exp B7/1/0/8", bus.data_out, bus.valid, bus.overflow, bus.count); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'hC3 || bus.count !== 4'd7) $display("FAIL repf_pop data=%h count=%0d exp C3/7", bus.data_out, bus.count); else passed++;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'hB6) $display("FAIL repf_pop2 data=%h exp B6", bus.data_out); else passed++;
    for (int i = 0; i < DEPTH - 2; i++) drive(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_passthrough();
    total++; if (bus.empty !== 1'b1) $display("FAIL pt_pre empty=%b exp 1", bus.empty); else passed++;
    drive(1'b1, 1'b1, 8'h5A);
    total++; if (bus.data_out !== 8'h5A || bus.valid !== 1'b1 || bus.count !== 4'd0) $display("FAIL pt_out data=%h valid=%b count=%0d exp 5A/1/0", bus.data_out, bus.valid, bus.count); else passed++;
    total++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0 || bus.empty !== 1'b1) $display("FAIL pt_flags unf=%b ovf=%b empty=%b exp 0/0/1", bus.underflow, bus.overflow, bus.empty); else passed++;
    drive(1'b0, 1'b0, 8'h00);
    total++; if (bus.valid !== 1'b0 || bus.data_out !== 8'h5A) $display("FAIL pt_hold valid=%b data=%h exp 0/5A", bus.valid, bus.data_out); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_mid_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_replace_full();
    test_passthrough();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
